// File: rtl/l2_bram_responder_pkg.sv
// l2_mem_pkg: shared FSM state, response struct and byte-merge helper for the L2 BRAM responder
package l2_mem_pkg;
  localparam int DW_MAX = 256;
  localparam int BW_MAX = DW_MAX / 8;
  localparam int IDW_MAX = 8;
  localparam logic [BW_MAX-1:0] BE_FULL = '1;
  typedef enum logic {IDLE, RMW} state_t;
  typedef struct packed {
    logic               valid;
    logic               is_load;
    logic [IDW_MAX-1:0] id;
  } resp_t;
  function automatic logic [DW_MAX-1:0] be_merge(input logic [DW_MAX-1:0] old_d, input logic [DW_MAX-1:0] new_d, input logic [BW_MAX-1:0] be);
    logic [DW_MAX-1:0] m;
    for (int i = 0; i < BW_MAX; i++) m[8*i +: 8] = be[i] ? new_d[8*i +: 8] : old_d[8*i +: 8];
    return m;
  endfunction
endpackage

// File: rtl/l2_bram_responder_if.sv
// l2_bram_responder_if: crossbar-side req/gnt/response bundle of one XBAR_L2 slave port
interface l2_bram_responder_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 2
);
  logic                    data_req_i;
  logic [ADDR_WIDTH-1:0]   data_add_i;
  logic                    data_wen_i;
  logic [DATA_WIDTH-1:0]   data_wdata_i;
  logic [DATA_WIDTH/8-1:0] data_be_i;
  logic [ID_WIDTH-1:0]     data_ID_i;
  logic                    data_gnt_o;
  logic                    data_r_valid_o;
  logic [DATA_WIDTH-1:0]   data_r_rdata_o;
  logic [ID_WIDTH-1:0]     data_r_ID_o;
  modport master (
    output data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    input  data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_ID_o
  );
  modport slave (
    input  data_req_i, data_add_i, data_wen_i, data_wdata_i, data_be_i, data_ID_i,
    output data_gnt_o, data_r_valid_o, data_r_rdata_o, data_r_ID_o
  );
endinterface

// File: rtl/l2_bram_responder_resp_pipe.sv
// l2_resp_pipe: RESP_LATENCY-deep delay line for the response struct and read data (pass-through at 0)
module l2_resp_pipe
  import l2_mem_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int RESP_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  resp_t                 i_resp,
  input  logic [DATA_WIDTH-1:0] i_rdata,
  output resp_t                 o_resp,
  output logic [DATA_WIDTH-1:0] o_rdata
);
  // Tap k is the input delayed by k cycles; the last register stage is never tapped.
  resp_t                 r_resp  [RESP_LATENCY+1];
  logic [DATA_WIDTH-1:0] r_rdata [RESP_LATENCY+1];
  resp_t                 w_resp  [RESP_LATENCY+1];
  logic [DATA_WIDTH-1:0] w_rdata [RESP_LATENCY+1];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= RESP_LATENCY; k++) begin
        r_resp[k]  <= '0;
        r_rdata[k] <= '0;
      end
    end else begin
      for (int k = 0; k <= RESP_LATENCY; k++) begin
        r_resp[k]  <= w_resp[k];
        r_rdata[k] <= w_rdata[k];
      end
    end
  end
  always_comb begin
    w_resp[0]  = i_resp;
    w_rdata[0] = i_rdata;
    for (int k = 1; k <= RESP_LATENCY; k++) begin
      w_resp[k]  = r_resp[k-1];
      w_rdata[k] = r_rdata[k-1];
    end
    o_resp  = w_resp[RESP_LATENCY];
    o_rdata = w_rdata[RESP_LATENCY];
  end
endmodule

// File: rtl/l2_bram_responder.sv
// l2_bram_responder: XBAR_L2 slave-port responder for a single-port BRAM, with RMW for partial stores.
// Define L2_RESP_STATS_EN to add the rd/wr/rmw transaction counters.
module l2_bram_responder
  import l2_mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int BE_WIDTH     = DATA_WIDTH / 8,
  parameter int ID_WIDTH     = 2,
  parameter int RESP_LATENCY = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  l2_bram_responder_if.slave    bus,
  output logic [ADDR_WIDTH-1:0] ADDRA_o,
  output logic [DATA_WIDTH-1:0] DINA_o,
  input  logic [DATA_WIDTH-1:0] DOUTA_i,
  output logic                  ENA_o,
  output logic                  WEA_o
`ifdef L2_RESP_STATS_EN
  ,
  output logic [31:0]           rd_cnt_o,
  output logic [31:0]           wr_cnt_o,
  output logic [31:0]           rmw_cnt_o
`endif
);
  state_t                r_state, w_next;
  logic                  w_gnt, w_part, w_full, w_none;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, w_merged, w_rdata;
  logic [BE_WIDTH-1:0]   r_be;
  logic [ID_WIDTH-1:0]   r_id;
  resp_t                 r_resp, w_resp;
  always_comb begin
    w_full   = bus.data_be_i == BE_WIDTH'(BE_FULL);
    w_none   = bus.data_be_i == '0;
    w_gnt    = rst_n && r_state == IDLE && bus.data_req_i;
    w_part   = w_gnt && bus.data_wen_i && !w_full && !w_none;
    w_merged = DATA_WIDTH'(be_merge(DW_MAX'(DOUTA_i), DW_MAX'(r_wdata), BW_MAX'(r_be)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb w_next = (r_state == IDLE && w_part) ? RMW : IDLE;
  // A partial store reads on its grant cycle and writes the merged word in RMW.
  always_comb begin
    bus.data_gnt_o = w_gnt;
    ENA_o   = r_state == RMW || (w_gnt && !(bus.data_wen_i && w_none));
    WEA_o   = r_state == RMW || (w_gnt && bus.data_wen_i && w_full);
    ADDRA_o = r_state == RMW ? r_addr : w_gnt ? bus.data_add_i : '0;
    DINA_o  = r_state == RMW ? w_merged : (w_gnt && bus.data_wen_i) ? bus.data_wdata_i : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_id    <= '0;
      r_resp  <= '0;
    end else begin
      if (w_part) begin
        r_addr  <= bus.data_add_i;
        r_wdata <= bus.data_wdata_i;
        r_be    <= bus.data_be_i;
        r_id    <= bus.data_ID_i;
      end
      r_resp <= r_state == RMW ? resp_t'{valid: 1'b1, is_load: 1'b0, id: IDW_MAX'(r_id)} :
                (w_gnt && !w_part) ? resp_t'{valid: 1'b1, is_load: !bus.data_wen_i, id: IDW_MAX'(bus.data_ID_i)} :
                '0;
    end
  end
  // DOUTA enters the pipe on the cycle after the read, aligned with its response.
  l2_resp_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .RESP_LATENCY(RESP_LATENCY)
  ) u_pipe (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_resp (r_resp),
    .i_rdata(DOUTA_i),
    .o_resp (w_resp),
    .o_rdata(w_rdata)
  );
  always_comb begin
    bus.data_r_valid_o = w_resp.valid;
    bus.data_r_rdata_o = w_resp.is_load ? w_rdata : '0;
    bus.data_r_ID_o    = ID_WIDTH'(w_resp.id);
  end
`ifdef L2_RESP_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_o  <= '0;
      wr_cnt_o  <= '0;
      rmw_cnt_o <= '0;
    end else begin
      if (w_gnt && !bus.data_wen_i) rd_cnt_o <= rd_cnt_o + 32'd1;
      if (w_gnt && bus.data_wen_i) wr_cnt_o <= wr_cnt_o + 32'd1;
      if (w_part) rmw_cnt_o <= rmw_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_l2_bram_responder.sv
// tb_l2_bram_responder: directed checks of two responders (latency 0 and 3) on behavioral BRAMs
module tb_l2_bram_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  l2_bram_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(2)) b0 ();
  l2_bram_responder_if #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .ID_WIDTH(2)) b3 ();
  logic [11:0] addra0, addra3;
  logic [31:0] dina0, dina3, dout0, dout3;
  logic        ena0, wea0, ena3, wea3;
  logic [31:0] mem0 [4096];
  logic [31:0] mem3 [4096];
`ifdef L2_RESP_STATS_EN
  logic [31:0] rd0, wr0, rmw0, rd3, wr3, rmw3;
`endif
  l2_bram_responder #(.RESP_LATENCY(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(b0),
    .ADDRA_o(addra0), .DINA_o(dina0), .DOUTA_i(dout0), .ENA_o(ena0), .WEA_o(wea0)
`ifdef L2_RESP_STATS_EN
    , .rd_cnt_o(rd0), .wr_cnt_o(wr0), .rmw_cnt_o(rmw0)
`endif
  );
  l2_bram_responder #(.RESP_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3),
    .ADDRA_o(addra3), .DINA_o(dina3), .DOUTA_i(dout3), .ENA_o(ena3), .WEA_o(wea3)
`ifdef L2_RESP_STATS_EN
    , .rd_cnt_o(rd3), .wr_cnt_o(wr3), .rmw_cnt_o(rmw3)
`endif
  );
  always @(posedge clk) if (ena0) begin
    if (wea0) mem0[addra0] <= dina0;
    else dout0 <= mem0[addra0];
  end
  always @(posedge clk) if (ena3) begin
    if (wea3) mem3[addra3] <= dina3;
    else dout3 <= mem3[addra3];
  end
  int n_chk = 0;
  int n_err = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drv0(input logic req, input logic wen, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be, input logic [1:0] id);
    @(posedge clk);
    #1;
    b0.data_req_i = req; b0.data_wen_i = wen; b0.data_add_i = a;
    b0.data_wdata_i = d; b0.data_be_i = be; b0.data_ID_i = id;
    @(negedge clk);
  endtask
  task automatic drv3(input logic req, input logic wen, input logic [11:0] a, input logic [31:0] d, input logic [3:0] be, input logic [1:0] id);
    @(posedge clk);
    #1;
    b3.data_req_i = req; b3.data_wen_i = wen; b3.data_add_i = a;
    b3.data_wdata_i = d; b3.data_be_i = be; b3.data_ID_i = id;
    @(negedge clk);
  endtask
  task automatic rsp0(input string tag, input logic v, input logic [1:0] id, input logic [31:0] d);
    chk({tag, ".valid"}, b0.data_r_valid_o, v);
    if (v) begin
      chk({tag, ".id"}, b0.data_r_ID_o, id);
      chk({tag, ".rdata"}, b0.data_r_rdata_o, d);
    end
  endtask
  initial begin
    b0.data_req_i = 1'b1; b0.data_wen_i = 1'b1; b0.data_add_i = 12'h03c;
    b0.data_wdata_i = 32'hffffffff; b0.data_be_i = 4'hf; b0.data_ID_i = 2'd3;
    b3.data_req_i = 1'b0; b3.data_wen_i = 1'b0; b3.data_add_i = '0;
    b3.data_wdata_i = '0; b3.data_be_i = '0; b3.data_ID_i = '0;
    #1 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst.gnt", b0.data_gnt_o, 0);
    chk("rst.valid", b0.data_r_valid_o, 0);
    chk("rst.rdata", b0.data_r_rdata_o, 0);
    chk("rst.id", b0.data_r_ID_o, 0);
    chk("rst.ena", ena0, 0);
    chk("rst.wea", wea0, 0);
    chk("rst.addra", addra0, 0);
    chk("rst.dina", dina0, 0);
    b0.data_req_i = 1'b0;
    rst_n = 1'b1;
    // full store then load of the same word
    drv0(1, 1, 12'h0fe, 32'hdea0bee0, 4'hf, 1);
    chk("fs.gnt", b0.data_gnt_o, 1);
    chk("fs.ena", ena0, 1);
    chk("fs.wea", wea0, 1);
    chk("fs.addra", addra0, 12'h0fe);
    chk("fs.dina", dina0, 32'hdea0bee0);
    rsp0("fs.early", 0, 0, 0);
    drv0(1, 0, 12'h0fe, 0, 0, 2);
    rsp0("fs", 1, 1, 0);
    chk("ld.wea", wea0, 0);
    drv0(0, 0, 0, 0, 0, 0);
    rsp0("ld", 1, 2, 32'hdea0bee0);
    drv0(0, 0, 0, 0, 0, 0);
    rsp0("ld.after", 0, 0, 0);
    // partial store: read-modify-write, grant blocked for one cycle
    drv0(1, 1, 12'h0ab, 32'h11223344, 4'hf, 0);
    drv0(1, 1, 12'h0ab, 32'hAABBCCDD, 4'b0101, 3);
    rsp0("pre", 1, 0, 0);
    chk("ps.gnt", b0.data_gnt_o, 1);
    chk("ps.ena", ena0, 1);
    chk("ps.wea", wea0, 0);
    drv0(1, 0, 12'h0ab, 0, 0, 0);
    chk("rmw.gnt", b0.data_gnt_o, 0);
    chk("rmw.ena", ena0, 1);
    chk("rmw.wea", wea0, 1);
    chk("rmw.addra", addra0, 12'h0ab);
    chk("rmw.dina", dina0, 32'h11BB33DD);
    rsp0("rmw", 0, 0, 0);
    drv0(1, 0, 12'h0ab, 0, 0, 0);
    chk("ps.regnt", b0.data_gnt_o, 1);
    rsp0("ps", 1, 3, 0);
    drv0(0, 0, 0, 0, 0, 0);
    rsp0("ps.ld", 1, 0, 32'h11BB33DD);
    // back-to-back loads
    for (int i = 1; i <= 3; i++) drv0(1, 1, 12'(i), 32'(i) * 32'h101, 4'hf, 0);
    for (int i = 1; i <= 5; i++) begin
      if (i <= 3) drv0(1, 0, 12'(i), 0, 0, 2'(i - 1));
      else drv0(0, 0, 0, 0, 0, 0);
      if (i > 1) rsp0("b2b", i < 5, 2'(i - 2), 32'(i - 1) * 32'h101);
    end
    // store with be=0 leaves the word alone
    drv0(1, 1, 12'h010, 32'hCAFEF00D, 4'hf, 0);
    drv0(1, 1, 12'h010, 32'h12345678, 4'h0, 1);
    chk("be0.gnt", b0.data_gnt_o, 1);
    chk("be0.ena", ena0, 0);
    drv0(1, 0, 12'h010, 0, 0, 2);
    rsp0("be0", 1, 1, 0);
    drv0(0, 0, 0, 0, 0, 0);
    rsp0("be0.ld", 1, 2, 32'hCAFEF00D);
`ifdef L2_RESP_STATS_EN
    chk("cnt.rd", rd0, 6);
    chk("cnt.wr", wr0, 8);
    chk("cnt.rmw", rmw0, 1);
`endif
    // RESP_LATENCY=3: responses appear four cycles after the grant
    drv3(1, 1, 12'h005, 32'hA5A5A5A5, 4'hf, 1);
    for (int k = 1; k <= 4; k++) begin
      drv3(0, 0, 0, 0, 0, 0);
      chk("l3s.valid", b3.data_r_valid_o, k == 4);
      if (k == 4) chk("l3s.id", b3.data_r_ID_o, 1);
    end
    drv3(1, 0, 12'h005, 0, 0, 3);
    for (int k = 1; k <= 4; k++) begin
      drv3(0, 0, 0, 0, 0, 0);
      chk("l3.valid", b3.data_r_valid_o, k == 4);
      if (k == 4) begin
        chk("l3.id", b3.data_r_ID_o, 3);
        chk("l3.rdata", b3.data_r_rdata_o, 32'hA5A5A5A5);
      end
    end
    // reset in the RMW cycle drops the write and the response
    drv0(1, 1, 12'h020, 32'h55667788, 4'hf, 0);
    drv0(1, 1, 12'h020, 32'h00000000, 4'b0011, 1);
    @(posedge clk);
    #1;
    b0.data_req_i = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rr.valid", b0.data_r_valid_o, 0);
    chk("rr.gnt", b0.data_gnt_o, 0);
    chk("rr.ena", ena0, 0);
    chk("rr.wea", wea0, 0);
    chk("rr.addra", addra0, 0);
    chk("rr.dina", dina0, 0);
    chk("rr.rdata", b0.data_r_rdata_o, 0);
    chk("rr.id", b0.data_r_ID_o, 0);
`ifdef L2_RESP_STATS_EN
    chk("rr.cnt.rd", rd0, 0);
    chk("rr.cnt.wr", wr0, 0);
    chk("rr.cnt.rmw", rmw0, 0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rr.valid1", b0.data_r_valid_o, 0);
    drv0(0, 0, 0, 0, 0, 0);
    chk("rr.valid2", b0.data_r_valid_o, 0);
    drv0(1, 0, 12'h020, 0, 0, 2);
    drv0(0, 0, 0, 0, 0, 0);
    rsp0("rr.ld", 1, 2, 32'h55667788);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
